conv_maxpool2x2: RTL and testbench
==================================

Name: conv_maxpool2x2

Overview:
Downstream of the convolver and its window-valid controller. Consumes the gated convolution output stream, one sample per cycle while in_valid is high, in raster order over a CONV_DIM x CONV_DIM feature map. Performs 2x2 stride-2 signed max pooling using a half-row buffer. Emits a (CONV_DIM/2) x (CONV_DIM/2) pooled map in raster order with a frame-done pulse.

Parameters:
DATA_WIDTH, 16, bit width of the signed two's-complement input and output samples.
IMAGE_SIZE, 28, input image edge length seen by the convolver.
KERNEL_SIZE, 5, convolution kernel edge length.
CONV_DIM (localparam), IMAGE_SIZE-KERNEL_SIZE+1 = 24, feature-map edge. Must be even; elaboration fails otherwise.
POOL_DIM (localparam), CONV_DIM/2 = 12, pooled-map edge.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  asynchronous active-low reset.
clear  in  1  synchronous frame abort. Returns counters and FSM to frame start; buffer contents are don't-care.
in_valid  in  1  convolver window-valid (enable); in_data is sampled only when this is high.
in_data  in  DATA_WIDTH  signed convolution result.
out_valid  out  1  one-cycle pulse per pooled sample.
out_data  out  DATA_WIDTH  signed pooled max, valid when out_valid is high.
out_row  out  clog2(POOL_DIM)  pooled row index of out_data.
out_col  out  clog2(POOL_DIM)  pooled column index of out_data.
frame_done  out  1  pulses together with out_valid for the last pooled sample (row = col = POOL_DIM-1).

Behaviour:
- Reset (async, rstn low): FSM = ROW_EVEN, col_cnt = 0, row_cnt = 0, pair register = 0. Outputs reset to out_valid = 0, out_data = 0, out_row = 0, out_col = 0, frame_done = 0. Row buffer needs no reset.
- Counters: col_cnt runs 0..CONV_DIM-1 and row_cnt runs 0..CONV_DIM-1. Both advance only on in_valid cycles. col_cnt wraps to 0 and increments row_cnt. row_cnt wraps to 0 after CONV_DIM-1. No advance in cycles where in_valid is low; all state holds.
- Gaps: in_valid may drop for any number of cycles, mid-row or between rows. Pooling is indexed by sample count, not by time.
- Pairing: on an even col_cnt, in_data is latched into pair_reg. On an odd col_cnt, hmax = signed max(pair_reg, in_data), and k = col_cnt>>1.
- FSM, two states:
  - ROW_EVEN: on odd col, buf[k] <= hmax. No output. After the last column, go to ROW_ODD.
  - ROW_ODD: on odd col, the result is signed max(buf[k], hmax). After the last column, go to ROW_EVEN.
- Output register (ROW_ODD, odd col): on the next clock edge, out_valid = 1, out_data = result, out_row = row_cnt>>1, out_col = k.
- Latency: one clock from the in_valid cycle carrying the bottom-right sample of a 2x2 block to out_valid.
- Output cadence: out_valid is high for exactly one cycle and low otherwise. It never asserts in ROW_EVEN. A frame yields exactly POOL_DIM^2 = 144 pulses.
- frame_done: asserted in the same cycle as the out_valid for row = col = POOL_DIM-1. The counters have already wrapped, so a new frame may begin in the very next cycle without a bubble.
- Ties: equal values give that value. Comparison is strictly signed, so -1 beats -32768 and 0 beats -1.
- clear: takes priority over in_valid in the same cycle; that sample is discarded. Outputs already registered still present for their one cycle.
- Reset mid-frame: all progress is lost. The next in_valid sample is treated as (row 0, col 0).

Decomposition:
- Shared package conv_pkg holds:
  - DATA_WIDTH, IMAGE_SIZE and KERNEL_SIZE defaults;
  - the CONV_DIM/POOL_DIM derivation function;
  - the pool FSM state enum (ROW_EVEN, ROW_ODD);
  - the signed-max function.
- One natural sub-module: pool_row_buffer, a POOL_DIM x DATA_WIDTH register file with one write port and one asynchronous read port, indexed by k.
- Counters, FSM and output register stay in the top module.

Test Plan:
1. Ramp frame: in_data = row*24+col, in_valid held high for 576 cycles -> 144 outputs, out_data(r,c) = (2r+1)*24+2c+1. First output is 25, one cycle after the sample at conv (1,1). Last output is 575 with frame_done = 1.
2. Signed values: 2x2 block {-5, -32768, -1, -200} -> -1. Block {0, -1, -1, -1} -> 0. Block {7, 7, 7, 7} -> 7.
3. Gapped input: same ramp frame with in_valid toggling 1,0,0 -> identical output sequence to scenario 1. out_valid stays single-cycle, and there is no output during ROW_EVEN rows.
4. Back-to-back frames: two ramp frames with no idle cycle -> 288 outputs. frame_done pulses twice; the second frame's first output is 25 at (0,0).
5. Mid-frame abort: clear pulsed after 300 samples (together with in_valid) -> that sample is ignored. A following full frame produces a correct 144-output sequence starting at (0,0). Repeat with rstn low for 3 cycles -> all outputs 0 during reset, and the same recovery.
6. Max placement: single +1000 placed at each of the four positions of block (5,7) within an all-zero frame -> out_data = 1000 only at out_row = 5, out_col = 7; all other outputs 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution pooling stage: default sizes, derived
// map dimensions, pooling FSM state type and the signed max helper.
package conv_pkg;

  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefImageSize  = 28;
  localparam int unsigned DefKernelSize = 5;

  // Widest sample the max helper handles; narrower samples are sign-extended into it.
  localparam int unsigned MaxWidth = 32;

  function automatic int unsigned calc_conv_dim(input int unsigned image_size,
                                                input int unsigned kernel_size);
    return image_size - kernel_size + 1;
  endfunction

  function automatic int unsigned calc_pool_dim(input int unsigned image_size,
                                                input int unsigned kernel_size);
    return calc_conv_dim(image_size, kernel_size) / 2;
  endfunction

  typedef enum logic {
    RowEven,
    RowOdd
  } pool_state_e;

  function automatic logic signed [MaxWidth-1:0] smax(input logic signed [MaxWidth-1:0] a,
                                                      input logic signed [MaxWidth-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_maxpool2x2_if.sv
// Sample stream into the pooler and pooled-sample stream out of it.
interface conv_maxpool2x2_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 4
);

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]         out_row;
  logic [IDX_WIDTH-1:0]         out_col;
  logic                         frame_done;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output frame_done
  );

endinterface

// File: rtl/pool_row_buffer.sv
// Half-row buffer for 2x2 pooling: one horizontal max per pooled column,
// one write port and one asynchronous read port.
module pool_row_buffer #(
  parameter int unsigned Depth = 12,
  parameter int unsigned Width = 16,
  parameter int unsigned IdxW  = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IdxW-1:0]         waddr,
  input  logic signed [Width-1:0] wdata,
  input  logic [IdxW-1:0]         raddr,
  output logic signed [Width-1:0] rdata
);

  logic signed [Width-1:0] mem_q [Depth];
  logic signed [Width-1:0] mem_d [Depth];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Contents are only read after being written in the same frame, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/conv_maxpool2x2.sv
// 2x2 stride-2 signed max pooling over a raster-ordered CONV_DIM x CONV_DIM
// feature map, emitting a POOL_DIM x POOL_DIM map with a frame-done pulse.
module conv_maxpool2x2
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned IMAGE_SIZE  = DefImageSize,
  parameter int unsigned KERNEL_SIZE = DefKernelSize
) (
  input logic               clk,
  input logic               rstn,
  input logic               clear,
  conv_maxpool2x2_if.slave  bus
);

  localparam int unsigned CONV_DIM = calc_conv_dim(IMAGE_SIZE, KERNEL_SIZE);
  localparam int unsigned POOL_DIM = calc_pool_dim(IMAGE_SIZE, KERNEL_SIZE);
  localparam int unsigned CntW     = (CONV_DIM > 1) ? $clog2(CONV_DIM) : 1;
  localparam int unsigned IdxW     = (POOL_DIM > 1) ? $clog2(POOL_DIM) : 1;

  generate
    if ((CONV_DIM % 2) != 0) begin : g_odd_dim
      $error("conv_maxpool2x2: CONV_DIM must be even");
    end
    if (DATA_WIDTH > MaxWidth) begin : g_wide_data
      $error("conv_maxpool2x2: DATA_WIDTH exceeds MaxWidth");
    end
  endgenerate

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  logic [CntW-1:0] col_q, col_d;
  logic [CntW-1:0] row_q, row_d;
  pool_state_e     state_q, state_d;
  data_t           pair_q, pair_d;

  logic            out_valid_q, out_valid_d;
  data_t           out_data_q, out_data_d;
  logic [IdxW-1:0] out_row_q, out_row_d;
  logic [IdxW-1:0] out_col_q, out_col_d;
  logic            frame_done_q, frame_done_d;

  logic            accept;
  logic            col_odd;
  logic            col_last;
  logic            row_last;
  logic [IdxW-1:0] k;
  data_t           hmax;
  data_t           buf_rdata;
  data_t           result;
  logic            buf_we;
  logic            out_fire;

  assign accept   = bus.in_valid & ~clear;
  assign col_odd  = col_q[0];
  assign col_last = (col_q == CntW'(CONV_DIM - 1));
  assign row_last = (row_q == CntW'(CONV_DIM - 1));
  assign k        = IdxW'(col_q >> 1);

  assign hmax   = DATA_WIDTH'(smax(MaxWidth'(pair_q), MaxWidth'(bus.in_data)));
  assign result = DATA_WIDTH'(smax(MaxWidth'(buf_rdata), MaxWidth'(hmax)));

  pool_row_buffer #(
    .Depth (POOL_DIM),
    .Width (DATA_WIDTH),
    .IdxW  (IdxW)
  ) u_row_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (k),
    .wdata (hmax),
    .raddr (k),
    .rdata (buf_rdata)
  );

  // Position counters advance on accepted samples only, so gaps are invisible.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (bus.in_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    pair_d = pair_q;
    if (accept && !col_odd) begin
      pair_d = bus.in_data;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = RowEven;
    end else if (bus.in_valid && col_last) begin
      unique case (state_q)
        RowEven: state_d = RowOdd;
        RowOdd:  state_d = RowEven;
        default: state_d = RowEven;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    buf_we   = 1'b0;
    out_fire = 1'b0;
    if (accept && col_odd) begin
      unique case (state_q)
        RowEven: buf_we   = 1'b1;
        RowOdd:  out_fire = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid_d  = out_fire;
    frame_done_d = out_fire & row_last & col_last;
    out_data_d   = out_data_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    if (out_fire) begin
      out_data_d = result;
      out_row_d  = IdxW'(row_q >> 1);
      out_col_d  = k;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RowEven;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_maxpool2x2.sv
// Scoreboard bench for conv_maxpool2x2: the driver queues the expected pooled
// sample as each block completes; a negedge monitor pops and compares.
module tb_conv_maxpool2x2;

  localparam int Dim  = 24;
  localparam int PDim = 12;
  localparam int N    = Dim * Dim;
  localparam int PN   = PDim * PDim;

  typedef struct {
    logic signed [15:0] data;
    int                 row;
    int                 col;
    bit                 done;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic clear;

  conv_maxpool2x2_if #(.DATA_WIDTH(16), .IDX_WIDTH(4)) bus ();

  conv_maxpool2x2 #(
    .DATA_WIDTH  (16),
    .IMAGE_SIZE  (28),
    .KERNEL_SIZE (5)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t               sb[$];
  int                 n_vec = 0;
  int                 n_err = 0;
  logic signed [15:0] img [N];
  logic signed [15:0] exp_pool [PN];
  int                 dr = 0;
  int                 dc = 0;

  // Monitor
  initial begin
    exp_t e;
    bit   prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.out_row !== 4'd0 ||
            bus.out_col !== 4'd0 || bus.frame_done !== 1'b0) begin
          n_err++;
          $display("FAIL reset_outputs: got v=%0b d=%0d r=%0d c=%0d fd=%0b, required all 0",
                   bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.frame_done);
        end
      end else if (bus.out_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got d=%0d r=%0d c=%0d, required no output",
                   bus.out_data, bus.out_row, bus.out_col);
        end else begin
          e = sb.pop_front();
          if (bus.out_data !== e.data || bus.out_row !== 4'(e.row) ||
              bus.out_col !== 4'(e.col) || bus.frame_done !== e.done || cyc != e.cyc) begin
            n_err++;
            $display({"FAIL pooled_out: got d=%0d r=%0d c=%0d fd=%0b cyc=%0d, ",
                      "required d=%0d r=%0d c=%0d fd=%0b cyc=%0d"},
                     bus.out_data, bus.out_row, bus.out_col, bus.frame_done, cyc,
                     e.data, e.row, e.col, e.done, e.cyc);
          end
        end
        if (prev_v) begin
          n_err++;
          $display("FAIL single_cycle: got out_valid high two cycles, required one");
        end
      end else if (bus.frame_done !== 1'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL frame_done_alone: got %0b without out_valid, required 0", bus.frame_done);
      end
      prev_v = (rstn === 1'b1) && (bus.out_valid === 1'b1);
    end
  end

  task automatic send(input bit v, input bit clr, input logic signed [15:0] d);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    clear        = clr;
    bus.in_data  = d;
    if (clr) begin
      dr = 0;
      dc = 0;
    end else if (v) begin
      if ((dr % 2 == 1) && (dc % 2 == 1)) begin
        sb.push_back('{data: exp_pool[(dr / 2) * PDim + dc / 2], row: dr / 2, col: dc / 2,
                       done: (dr == Dim - 1) && (dc == Dim - 1), cyc: cyc + 1});
      end
      if (dc == Dim - 1) begin
        dc = 0;
        dr = (dr == Dim - 1) ? 0 : dr + 1;
      end else begin
        dc = dc + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 16'sh7fff);
  endtask

  task automatic run_frame(input int gap);
    for (int i = 0; i < N; i++) begin
      send(1'b1, 1'b0, img[i]);
      for (int g = 0; g < gap; g++) send(1'b0, 1'b0, 16'sh7fff);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    clear        = 1'b0;
    dr           = 0;
    dc           = 0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Ramp image: pooled max is always the bottom-right sample of each block.
  task automatic set_ramp();
    for (int i = 0; i < N; i++) img[i] = 16'(i);
    for (int r = 0; r < PDim; r++)
      for (int c = 0; c < PDim; c++)
        exp_pool[r * PDim + c] = 16'((2 * r + 1) * Dim + 2 * c + 1);
  endtask

  task automatic set_zero();
    for (int i = 0; i < N; i++) img[i] = 16'sd0;
    for (int i = 0; i < PN; i++) exp_pool[i] = 16'sd0;
  endtask

  initial begin
    rstn         = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'sd0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Ramp frame, continuous
    set_ramp();
    run_frame(0);
    idle(4);

    // Signed blocks at pooled (0,0), (0,1), (0,2)
    set_zero();
    img[0]  = -16'sd5;  img[1]  = -16'sd32768; img[24] = -16'sd1; img[25] = -16'sd200;
    img[2]  = 16'sd0;   img[3]  = -16'sd1;     img[26] = -16'sd1; img[27] = -16'sd1;
    img[4]  = 16'sd7;   img[5]  = 16'sd7;      img[28] = 16'sd7;  img[29] = 16'sd7;
    exp_pool[0] = -16'sd1;
    exp_pool[1] = 16'sd0;
    exp_pool[2] = 16'sd7;
    run_frame(0);
    idle(4);

    // Gapped ramp frame
    set_ramp();
    run_frame(2);
    idle(4);

    // Back-to-back ramp frames
    run_frame(0);
    run_frame(0);
    idle(4);

    // Abort with clear alongside sample 300, then a full frame
    for (int i = 0; i < 300; i++) send(1'b1, 1'b0, img[i]);
    send(1'b1, 1'b1, img[300]);
    run_frame(0);
    idle(4);

    // Abort with reset, then a full frame
    for (int i = 0; i < 300; i++) send(1'b1, 1'b0, img[i]);
    do_reset();
    run_frame(0);
    idle(4);

    // +1000 at each position of block (5,7) in a zero frame
    for (int p = 0; p < 4; p++) begin
      set_zero();
      img[(10 + p / 2) * Dim + 14 + p % 2] = 16'sd1000;
      exp_pool[5 * PDim + 7] = 16'sd1000;
      run_frame(0);
      idle(2);
    end

    idle(5);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drained: got %0d outputs still outstanding, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
